memory_arbiter: RTL
===================

# memory_arbiter

Shares the single-port, word-wide data RAM between two requesters: port 0 (core data path) and port 1 (debug/loader). The block arbitrates round-robin, sequences each transaction, and performs read-modify-write for partial-word stores, so the RAM never needs byte enables. It sits between the requesters and the RAM, and is clocked on the core clock's rising edge.

## Interface
- ADDR_WIDTH, 12, word address width of RAM and request ports
- clock  in  1  rising-edge clock
- reset  in  1  reset, asynchronous, active-high
- req0, req1  in  1  request valid; held with its fields until grant
- we0, we1  in  1  1 = write, 0 = read
- addr0, addr1  in  ADDR_WIDTH  word address
- wdata0, wdata1  in  32  write data
- be0, be1  in  4  byte enables (bit k selects byte k, bits [8k+7:8k]); ignored for reads
- gnt0, gnt1  out  1  request accepted at this rising edge (combinational, only in IDLE)
- resp0, resp1  out  1  one-cycle completion pulse, for reads and writes
- rdata0, rdata1  out  32  read data; equals mem_rdata when respN=1, else 0
- busy  out  1  state != IDLE
- mem_addr  out  ADDR_WIDTH  RAM address
- mem_we  out  1  RAM word write strobe
- mem_wdata  out  32  RAM write data
- mem_rdata  in  32  RAM read data, valid the cycle after its address is presented with mem_we=0

## Operation
- States: IDLE, ACCESS, WAIT, WRITEBACK. One-hot is allowed.
- IDLE:
  - If exactly one req is high, grant it.
  - If both are high, grant the port the round-robin pointer favours.
  - On the grant edge, latch id, we, addr, wdata and be. Move the pointer to favour the other port. Go to ACCESS.
  - Grants issue only in IDLE; requests never queue.
- ACCESS: mem_addr = latched addr.
  - Full write (be=4'hF): mem_we=1, mem_wdata=wdata, resp[id]=1, go to IDLE.
  - Null write (be=4'h0): mem_we=0, resp[id]=1, go to IDLE. The RAM is untouched.
  - Read or partial write: mem_we=0, go to WAIT.
- WAIT: mem_addr is held.
  - Read: resp[id]=1, rdata[id]=mem_rdata, go to IDLE.
  - Partial write: register merged word, byte k = be[k] ? wdata byte k : mem_rdata byte k. Go to WRITEBACK.
- WRITEBACK: mem_addr = latched addr, mem_we=1, mem_wdata=merged, resp[id]=1, go to IDLE.
- Illegal state encoding goes to IDLE with no memory write.
- A port's gnt and resp are never high together with the other port's.
- Out of reset the pointer favours port 0.
- mem_we is high only in ACCESS (full write) or WRITEBACK.
- In IDLE, mem_we=0 and mem_addr/mem_wdata are don't-care.

## Timing
- Cycle 0 = the cycle gnt is high. The RAM sees the request from cycle 1.
- Read: mem read in cycle 1, resp/rdata in cycle 2. Next grant possible in cycle 3.
- Full or null write: write and resp in cycle 1. Next grant possible in cycle 2.
- Partial write: read in cycle 1, merge in cycle 2, write and resp in cycle 3. Next grant possible in cycle 4.
- Requester fields may change the cycle after gnt.
- Reset, asynchronous and effective immediately:
  - State goes to IDLE and the pointer goes to port 0.
  - All outputs go to 0: gnt, resp, rdata, busy, mem_we, mem_addr, mem_wdata.
  - An in-flight transaction is dropped with no resp and no RAM write, including mid-WRITEBACK.
- Deasserting req before grant withdraws the request with no side effect.

## Test plan
- Reset, then req0 read addr 0x010 with mem[0x010]=0xDEADBEEF -> gnt0 in cycle 0; mem_addr=0x010 and mem_we=0 in cycle 1; resp0=1 and rdata0=0xDEADBEEF in cycle 2; busy high in cycles 1-2.
- mem[0x020]=0x11223344, req1 write be=4'b0010 wdata=0xAABBCCDD -> mem_we only in cycle 3, mem_wdata=0x1122CC44, resp1 in cycle 3, mem[0x020]=0x1122CC44 after.
- req0 write be=4'hF addr 0x005 wdata=0xCAFEF00D -> mem_we in cycle 1 only with 0xCAFEF00D; resp0 in cycle 1; gnt possible again in cycle 2. req0 write be=4'h0 -> resp0 in cycle 1, mem_we never high.
- req0 and req1 both held high issuing back-to-back reads after reset -> grants in order 0,1,0,1 at cycles 0,3,6,9; resps at cycles 2,5,8,11 on the matching port.
- Partial write started and reset asserted during WRITEBACK -> mem_we, resp and busy drop to 0 in the same cycle; RAM word unchanged; the first grant after reset goes to port 0 when both request.

Source files
------------

// File: rtl/memory_arbiter_if.sv
// Bundle of requester-side and RAM-side signals shared by memory_arbiter and its environment.
// The slave view is the arbiter; the master view drives requests and models the RAM.
interface memory_arbiter_if #(
    parameter int ADDR_WIDTH = 12
) ();
    logic                  req0;
    logic                  req1;
    logic                  we0;
    logic                  we1;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [31:0]           wdata0;
    logic [31:0]           wdata1;
    logic [3:0]            be0;
    logic [3:0]            be1;
    logic                  gnt0;
    logic                  gnt1;
    logic                  resp0;
    logic                  resp1;
    logic [31:0]           rdata0;
    logic [31:0]           rdata1;
    logic                  busy;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_we;
    logic [31:0]           mem_wdata;
    logic [31:0]           mem_rdata;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, be0, be1, mem_rdata,
        output gnt0, gnt1, resp0, resp1, rdata0, rdata1, busy, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, be0, be1, mem_rdata,
        input  gnt0, gnt1, resp0, resp1, rdata0, rdata1, busy, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one word-wide single-port RAM between two requesters,
// turning partial-word stores into read-modify-write so the RAM needs no byte enables.
module memory_arbiter #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic             clock,
    input  logic             reset,
    memory_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ACCESS    = 2'd1,
        ST_WAIT      = 2'd2,
        ST_WRITEBACK = 2'd3
    } state_t;

    // Byte k of the result comes from new_word when be[k] is set, else from old_word.
    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  be
    );
        logic [31:0] merged;
        merged = old_word;
        for (int k = 0; k < 4; k++) begin
            if (be[k]) begin
                merged[8*k +: 8] = new_word[8*k +: 8];
            end else begin
                merged[8*k +: 8] = old_word[8*k +: 8];
            end
        end
        return merged;
    endfunction

    state_t                state_r;
    state_t                state_s;
    logic                  id_r;
    logic                  we_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [31:0]           wdata_r;
    logic [3:0]            be_r;
    logic [31:0]           merged_r;
    logic                  rr_r;

    logic                  grant_s;
    logic                  grant_id_s;
    logic                  resp_s;
    logic                  merge_en_s;
    logic                  mem_we_s;
    logic [ADDR_WIDTH-1:0] mem_addr_s;
    logic [31:0]           mem_wdata_s;

    // State register; reset abandons any in-flight transaction.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state, grant selection and RAM strobes.
    always_comb begin
        state_s     = state_r;
        grant_s     = 1'b0;
        grant_id_s  = 1'b0;
        resp_s      = 1'b0;
        merge_en_s  = 1'b0;
        mem_we_s    = 1'b0;
        mem_addr_s  = '0;
        mem_wdata_s = 32'h0000_0000;
        case (state_r)
            ST_IDLE: begin
                if (bus.req0 && bus.req1) begin
                    grant_id_s = rr_r;
                end else if (bus.req1) begin
                    grant_id_s = 1'b1;
                end else begin
                    grant_id_s = 1'b0;
                end
                grant_s = bus.req0 | bus.req1;
                if (grant_s) begin
                    state_s = ST_ACCESS;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                mem_addr_s = addr_r;
                if (we_r && (be_r == 4'hF)) begin
                    mem_we_s    = 1'b1;
                    mem_wdata_s = wdata_r;
                    resp_s      = 1'b1;
                    state_s     = ST_IDLE;
                end else if (we_r && (be_r == 4'h0)) begin
                    resp_s  = 1'b1;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_WAIT: begin
                mem_addr_s = addr_r;
                if (!we_r) begin
                    resp_s  = 1'b1;
                    state_s = ST_IDLE;
                end else begin
                    merge_en_s = 1'b1;
                    state_s    = ST_WRITEBACK;
                end
            end
            ST_WRITEBACK: begin
                mem_addr_s  = addr_r;
                mem_we_s    = 1'b1;
                mem_wdata_s = merged_r;
                resp_s      = 1'b1;
                state_s     = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Capture the granted request and hand round-robin priority to the other port.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            id_r    <= 1'b0;
            we_r    <= 1'b0;
            addr_r  <= '0;
            wdata_r <= 32'h0000_0000;
            be_r    <= 4'h0;
            rr_r    <= 1'b0;
        end else if (grant_s) begin
            id_r    <= grant_id_s;
            we_r    <= grant_id_s ? bus.we1    : bus.we0;
            addr_r  <= grant_id_s ? bus.addr1  : bus.addr0;
            wdata_r <= grant_id_s ? bus.wdata1 : bus.wdata0;
            be_r    <= grant_id_s ? bus.be1    : bus.be0;
            rr_r    <= ~grant_id_s;
        end else begin
            id_r    <= id_r;
            we_r    <= we_r;
            addr_r  <= addr_r;
            wdata_r <= wdata_r;
            be_r    <= be_r;
            rr_r    <= rr_r;
        end
    end

    // Merged word for a partial store, built from the RAM word read in ACCESS.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            merged_r <= 32'h0000_0000;
        end else if (merge_en_s) begin
            merged_r <= merge_bytes(bus.mem_rdata, wdata_r, be_r);
        end else begin
            merged_r <= merged_r;
        end
    end

    // Grants are combinational from req, so reset must mask them explicitly.
    assign bus.gnt0      = grant_s & ~grant_id_s & ~reset;
    assign bus.gnt1      = grant_s &  grant_id_s & ~reset;
    assign bus.resp0     = resp_s & ~id_r;
    assign bus.resp1     = resp_s &  id_r;
    assign bus.rdata0    = bus.resp0 ? bus.mem_rdata : 32'h0000_0000;
    assign bus.rdata1    = bus.resp1 ? bus.mem_rdata : 32'h0000_0000;
    assign bus.busy      = (state_r != ST_IDLE);
    assign bus.mem_we    = mem_we_s;
    assign bus.mem_addr  = mem_addr_s;
    assign bus.mem_wdata = mem_wdata_s;

endmodule
